// File: rtl/jhash_packer.sv
// jhash_packer: packs a 32-bit word stream into 3-word a/b/c blocks for the
// jhash core, presenting full blocks with stream_valid and the final partial
// block with stream_done/stream_left. Handles the single-block start kick and
// the post-ack hold-off so stream_done never overlaps the core's mixing.
//
// state      | meaning
// COLLECT    | accepting words into lanes 0..2
// PRESENT    | full block on stream_*, waiting for stream_ack
// FINAL_WAIT | last word captured; waiting for kick decision or hold-off
// KICK       | one-cycle stream_valid to start an idle core (single block)
// FINAL      | stream_done high with final block until hash_done
// END        | message finished; idle until reset
module jhash_packer #(
    parameter int HOLDOFF = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] stream_data0,
    output logic [31:0] stream_data1,
    output logic [31:0] stream_data2,
    output logic        stream_valid,
    output logic        stream_done,
    output logic [1:0]  stream_left,
    input  logic        stream_ack,
    input  logic        hash_done,
    output logic        msg_done
);

    localparam logic [2:0] COLLECT    = 3'd0;
    localparam logic [2:0] PRESENT    = 3'd1;
    localparam logic [2:0] FINAL_WAIT = 3'd2;
    localparam logic [2:0] KICK       = 3'd3;
    localparam logic [2:0] FINAL      = 3'd4;
    localparam logic [2:0] END        = 3'd5;

    localparam int HW = $clog2(HOLDOFF + 1);

    logic [2:0]    state;
    logic [1:0]    count;
    logic          first_blk;
    logic [HW-1:0] holdoff;
    logic [31:0]   lane0;
    logic [31:0]   lane1;
    logic [31:0]   lane2;
    logic          xfer;

    assign in_ready = (state == COLLECT);
    assign xfer     = in_valid && in_ready;

    // State, lane capture, word count, hold-off timer and msg_done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            count     <= 2'd0;
            first_blk <= 1'b1;
            holdoff   <= '0;
            lane0     <= 32'd0;
            lane1     <= 32'd0;
            lane2     <= 32'd0;
            msg_done  <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            if (holdoff != '0)
                holdoff <= holdoff - HW'(1);
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        case (count)
                            2'd0:    lane0 <= in_data;
                            2'd1:    lane1 <= in_data;
                            default: lane2 <= in_data;
                        endcase
                        if (in_last) begin
                            // count becomes the number of words in the final block
                            count <= count + 2'd1;
                            state <= FINAL_WAIT;
                        end else if (count == 2'd2) begin
                            state <= PRESENT;
                        end else begin
                            count <= count + 2'd1;
                        end
                    end
                end
                PRESENT: begin
                    if (stream_ack) begin
                        holdoff   <= HW'(HOLDOFF - 1);
                        first_blk <= 1'b0;
                        count     <= 2'd0;
                        lane0     <= 32'd0;
                        lane1     <= 32'd0;
                        lane2     <= 32'd0;
                        state     <= COLLECT;
                    end
                end
                FINAL_WAIT: begin
                    // Leave when holdoff is 0 in the cycle FINAL becomes visible,
                    // so done lands exactly HOLDOFF cycles after the ack cycle.
                    if (first_blk)
                        state <= KICK;
                    else if (holdoff <= HW'(1))
                        state <= FINAL;
                end
                KICK: begin
                    state <= FINAL;
                end
                FINAL: begin
                    if (hash_done) begin
                        msg_done <= 1'b1;
                        state    <= END;
                    end
                end
                END: begin
                    state <= END;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign stream_valid = (state == PRESENT) || (state == KICK);
    assign stream_done  = (state == FINAL);
    assign stream_left  = ((state == FINAL_WAIT) || (state == KICK) || (state == FINAL))
                          ? count : 2'd0;
    assign stream_data0 = (state == END) ? 32'd0 : lane0;
    assign stream_data1 = (state == END) ? 32'd0 : lane1;
    assign stream_data2 = (state == END) ? 32'd0 : lane2;

endmodule

// File: tb/tb_jhash_packer.sv
// Self-checking bench for jhash_packer: directed scenarios plus random
// messages checked against a block-level model of the packing rules.
module tb_jhash_packer;

    localparam int HOLDOFF = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] stream_data0;
    logic [31:0] stream_data1;
    logic [31:0] stream_data2;
    logic        stream_valid;
    logic        stream_done;
    logic [1:0]  stream_left;
    logic        stream_ack;
    logic        hash_done;
    logic        msg_done;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] msg [0:63];

    jhash_packer #(.HOLDOFF(HOLDOFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .stream_data0 (stream_data0),
        .stream_data1 (stream_data1),
        .stream_data2 (stream_data2),
        .stream_valid (stream_valid),
        .stream_done  (stream_done),
        .stream_left  (stream_left),
        .stream_ack   (stream_ack),
        .hash_done    (hash_done),
        .msg_done     (msg_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
        stream_ack = 1'b0; hash_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_valid"}, {31'd0, stream_valid}, 32'd0);
        chk({tag, "_done"},  {31'd0, stream_done}, 32'd0);
        chk({tag, "_left"},  {30'd0, stream_left}, 32'd0);
        chk({tag, "_mdone"}, {31'd0, msg_done}, 32'd0);
        chk({tag, "_d0"}, stream_data0, 32'd0);
        chk({tag, "_d1"}, stream_data1, 32'd0);
        chk({tag, "_d2"}, stream_data2, 32'd0);
    endtask

    function automatic logic [31:0] final_lane(input int n, input int j);
        int nfull = (n - 1) / 3;
        int lastsz = n - 3 * nfull;
        return (j < lastsz) ? msg[3 * nfull + j] : 32'd0;
    endfunction

    // Drives msg[0:n-1], acks full blocks after ack_lat cycles, and checks each
    // block, the kick, and the final block. hd_lat < 0 returns as soon as
    // stream_done is seen (no hash_done). done_gap = cycles from last ack to done.
    task automatic run_msg(input int n, input int ack_lat, input bit gaps,
                           input bit hd_in_present, input int hd_lat, output int done_gap);
        int nfull = (n - 1) / 3;
        int lastsz = n - 3 * nfull;
        int wi = 0, bi = 0, wcnt = 0, guard = 0, cnt = 0;
        int t_ack = -1000, kick_cyc = -1000;
        bit kick_seen = 0, done_seen = 0, acked_prev = 0, last_acc = 0;
        done_gap = -1;
        while (!done_seen && guard < 3000) begin
            @(negedge clk);
            guard++;
            stream_ack = 1'b0;
            hash_done  = 1'b0;
            if (acked_prev) chk("ready_after_ack", {31'd0, in_ready}, 32'd1);
            acked_prev = 0;
            chk("valid_done_excl", {31'd0, stream_valid & stream_done}, 32'd0);
            if (stream_valid) begin
                if (bi < nfull) begin
                    chk("blk_d0", stream_data0, msg[3 * bi]);
                    chk("blk_d1", stream_data1, msg[3 * bi + 1]);
                    chk("blk_d2", stream_data2, msg[3 * bi + 2]);
                    chk("blk_ready", {31'd0, in_ready}, 32'd0);
                    if (hd_in_present && wcnt == 1) hash_done = 1'b1;
                    if (wcnt >= ack_lat) begin
                        stream_ack = 1'b1;
                        t_ack = cyc;
                        bi++;
                        wcnt = 0;
                        acked_prev = 1;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    chk("kick_once", {31'd0, kick_seen}, 32'd0);
                    kick_seen = 1;
                    kick_cyc = cyc;
                end
            end
            if (stream_done) begin
                done_seen = 1;
                chk("fin_left", {30'd0, stream_left}, lastsz);
                chk("fin_d0", stream_data0, final_lane(n, 0));
                chk("fin_d1", stream_data1, final_lane(n, 1));
                chk("fin_d2", stream_data2, final_lane(n, 2));
                chk("fin_blocks", bi, nfull);
                chk("fin_kick", {31'd0, kick_seen}, {31'd0, (nfull == 0)});
                if (nfull == 0) begin
                    chk("kick_to_done", cyc - kick_cyc, 32'd1);
                end else begin
                    done_gap = cyc - t_ack;
                    chk("holdoff_min", {31'd0, (done_gap >= HOLDOFF)}, 32'd1);
                end
            end
            if (wi < n) begin
                if (gaps && in_ready && (!in_valid || last_acc) && $urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0; in_last = 1'b0; last_acc = 0;
                end else begin
                    in_valid = 1'b1;
                    in_data  = msg[wi];
                    in_last  = (wi == n - 1);
                    last_acc = in_ready;
                    if (in_ready) wi++;
                end
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
        end
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        if (hd_lat >= 0) begin
            repeat (hd_lat) begin
                @(negedge clk);
                chk("hold_done", {31'd0, stream_done}, 32'd1);
                chk("hold_left", {30'd0, stream_left}, lastsz);
                chk("hold_d0", stream_data0, final_lane(n, 0));
            end
            @(negedge clk);
            hash_done = 1'b1;
            repeat (4) begin
                @(negedge clk);
                hash_done = 1'b0;
                cnt += msg_done;
            end
            chk("msg_done_once", cnt, 32'd1);
            chk("end_done", {31'd0, stream_done}, 32'd0);
            chk("end_valid", {31'd0, stream_valid}, 32'd0);
            chk("end_ready", {31'd0, in_ready}, 32'd0);
            chk("end_d0", stream_data0, 32'd0);
        end
    endtask

    initial begin
        int gap;
        int n;

        // Reset state
        do_reset();
        chk_reset_outputs("rst");

        // Single word: kick then done with left=1
        msg[0] = 32'h1111_1111;
        run_msg(1, 0, 0, 0, 5, gap);

        // Three words: kick only, left=3
        do_reset();
        for (int i = 0; i < 3; i++) msg[i] = i + 1;
        run_msg(3, 0, 0, 0, 3, gap);

        // Five words: done exactly HOLDOFF cycles after the ack
        do_reset();
        for (int i = 0; i < 5; i++) msg[i] = i + 1;
        run_msg(5, 0, 0, 0, 2, gap);
        chk("holdoff_exact", gap, HOLDOFF);

        // Back-pressure: ack withheld 20 cycles
        do_reset();
        for (int i = 0; i < 7; i++) msg[i] = 32'hA000_0000 + i;
        run_msg(7, 20, 0, 0, 1, gap);

        // hash_done during PRESENT is ignored
        do_reset();
        for (int i = 0; i < 4; i++) msg[i] = 32'hB000_0000 + i;
        run_msg(4, 3, 0, 1, 1, gap);

        // Asynchronous reset while in FINAL, then a 2-word message
        do_reset();
        for (int i = 0; i < 4; i++) msg[i] = 32'hC000_0000 + i;
        run_msg(4, 1, 0, 0, -1, gap);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        msg[0] = 32'hD000_0001; msg[1] = 32'hD000_0002;
        run_msg(2, 0, 0, 0, 1, gap);

        // Random messages
        for (int k = 0; k < 10; k++) begin
            do_reset();
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) msg[i] = $urandom;
            run_msg(n, $urandom_range(0, 5), 1, $urandom_range(0, 1), $urandom_range(0, 4), gap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
